alu_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the IL-style ALU and its instruction sequencer.
//   - opcode constants (8-bit op_code space)
//   - source-select encoding shared by both ALU operand ports
//   - sequencer state encoding
//   - instruction word field layout: [op_code | src(2) | operand(AW)]
package alu_pkg;

    localparam logic [7:0] OP_AND  = 8'h00;
    localparam logic [7:0] OP_OR   = 8'h01;
    localparam logic [7:0] OP_XOR  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h03;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_NOT  = 8'h06;
    localparam logic [7:0] OP_S    = 8'h1B;
    localparam logic [7:0] OP_R    = 8'h1C;
    localparam logic [7:0] OP_ST   = 8'h1D;
    localparam logic [7:0] OP_STN  = 8'h1E;
    localparam logic [7:0] OP_LD   = 8'h1F;
    localparam logic [7:0] OP_LDN  = 8'h20;
    localparam logic [7:0] OP_JMP  = 8'h21;
    localparam logic [7:0] OP_JMPC = 8'h22;
    localparam logic [7:0] OP_END  = 8'h3F;

    typedef enum logic [1:0] {
        SRC_RF   = 2'd0,
        SRC_BIT  = 2'd1,
        SRC_WORD = 2'd2,
        SRC_IMM  = 2'd3
    } src_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OPRD,
        S_EXEC,
        S_HALT
    } state_e;

    // Operand sits at the bottom, the 2-bit source field above it, op_code on top.
    localparam int F_OPND_LSB = 0;
    localparam int F_SRC_W    = 2;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches instructions, stages data-memory operands, drives the
// combinational ALU and retires results into CR or back to data memory.
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 pulse, (re)starts at PC=0 from IDLE/HALT
//   busy, halted          status
//   imem_req/addr/ack/data  program fetch handshake
//   dmem_addr/re/rdata    operand read (rdata valid the cycle after re)
//   dmem_we/wdata         result write
//   alu_*                 ALU operand/control outputs and result/carry inputs
//   cr                    accumulator debug view
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IWIDTH = 8,
    parameter int PC_W   = 8,
    parameter int AW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   halted,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [IWIDTH+2+AW-1:0] imem_data,
    output logic [AW-1:0]          dmem_addr,
    output logic                   dmem_re,
    input  logic [WIDTH-1:0]       dmem_rdata,
    output logic                   dmem_we,
    output logic [WIDTH-1:0]       dmem_wdata,
    output logic [IWIDTH-1:0]      alu_op,
    output logic [1:0]             alu_src1,
    output logic [1:0]             alu_src2,
    output logic [WIDTH-1:0]       alu_rf_a,
    output logic [WIDTH-1:0]       alu_word,
    output logic                   alu_bit,
    output logic [WIDTH-1:0]       alu_imm,
    output logic                   alu_c_in,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_c_out,
    input  logic                   alu_flag_valid,
    output logic [WIDTH-1:0]       cr
);

    localparam int IR_W    = IWIDTH + F_SRC_W + AW;
    localparam int SRC_LSB = F_OPND_LSB + AW;
    localparam int OP_LSB  = SRC_LSB + F_SRC_W;

    state_e            state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx;
    logic [IR_W-1:0]   ir;
    logic [WIDTH-1:0]  cr_q, opnd, imm_h;
    logic              carry;
    logic [IWIDTH-1:0] op_h;
    logic [1:0]        src1_h, src2_h;

    logic [IWIDTH-1:0] op, f_op;
    logic [1:0]        src, f_src;
    logic [AW-1:0]     operand;

    assign op      = ir[OP_LSB +: IWIDTH];
    assign src     = ir[SRC_LSB +: F_SRC_W];
    assign operand = ir[F_OPND_LSB +: AW];
    assign f_op    = imem_data[OP_LSB +: IWIDTH];
    assign f_src   = imem_data[SRC_LSB +: F_SRC_W];

    // Decode of the instruction held in IR (meaningful in EXEC).
    logic is_ld, is_st, is_set, is_jmp, is_jmpc, cr_nz, jump, alu_use;
    logic wr_en, cr_load, live, mem_src;
    logic [1:0]       exec_src1, exec_src2;
    logic [WIDTH-1:0] exec_word;

    assign is_ld     = (op == OP_LD) || (op == OP_LDN) || (op == OP_NOT);
    assign is_st     = (op == OP_ST) || (op == OP_STN);
    assign is_set    = (op == OP_S)  || (op == OP_R);
    assign is_jmp    = (op == OP_JMP);
    assign is_jmpc   = (op == OP_JMPC);
    assign cr_nz     = |cr_q;
    assign jump      = is_jmp || (is_jmpc && cr_nz);
    assign alu_use   = !(is_jmp || is_jmpc);
    // ST with a non-word source degenerates to a NOP: no write, CR untouched.
    assign wr_en     = (is_st && src == SRC_WORD) || (is_set && cr_nz);
    assign cr_load   = !(is_st || is_set);
    assign live      = (state == S_EXEC) && alu_use;
    assign mem_src   = (src == SRC_BIT) || (src == SRC_WORD);
    assign exec_src1 = is_ld ? src : SRC_RF;
    assign exec_src2 = is_ld ? SRC_RF : src;
    // Read data arrives during EXEC (one cycle after the OPRD strobe), so the
    // ALU sees it directly; opnd captures it at the end of EXEC and holds it.
    assign exec_word = mem_src ? dmem_rdata : opnd;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        imem_req = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (f_op == OP_END)                          state_nx = S_HALT;
                    else if (f_src == SRC_BIT || f_src == SRC_WORD) state_nx = S_OPRD;
                    else                                         state_nx = S_EXEC;
                end
            end
            S_OPRD: begin
                dmem_re  = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                dmem_we  = wr_en;
                pc_nx    = jump ? operand[PC_W-1:0] : pc + PC_W'(1);
                state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            cr_q   <= '0;
            carry  <= 1'b0;
            opnd   <= '0;
            imm_h  <= '0;
            op_h   <= '0;
            src1_h <= '0;
            src2_h <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_FETCH && imem_ack) ir <= imem_data;
            if (live) begin
                op_h   <= op;
                src1_h <= exec_src1;
                src2_h <= exec_src2;
                imm_h  <= WIDTH'(operand);
                opnd   <= exec_word;
                if (cr_load)        cr_q  <= alu_out;
                if (alu_flag_valid) carry <= alu_c_out;
            end
        end
    end

    // ALU-facing signals show live values only while an ALU instruction
    // executes; otherwise they hold what the last such EXEC drove.
    assign alu_op     = live ? op : op_h;
    assign alu_src1   = live ? exec_src1 : src1_h;
    assign alu_src2   = live ? exec_src2 : src2_h;
    assign alu_word   = live ? exec_word : opnd;
    assign alu_bit    = alu_word[0];
    assign alu_imm    = live ? WIDTH'(operand) : imm_h;
    assign alu_rf_a   = cr_q;
    assign alu_c_in   = carry;
    assign cr         = cr_q;
    assign busy       = (state != S_IDLE) && (state != S_HALT);
    assign halted     = (state == S_HALT);
    assign imem_addr  = pc;
    assign dmem_addr  = operand;
    assign dmem_wdata = alu_out;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a behavioural ALU,
// program ROM (programmable ack delay) and synchronous data memory.
// Fetch addresses and memory writes are predicted into queues and compared
// as the sequencer produces them.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 8, IWIDTH = 8, PC_W = 8, AW = 8;
    localparam int IW = IWIDTH + 2 + AW;

    logic clk = 1'b0;
    logic rst, start;
    logic busy, halted, imem_req, imem_ack;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [AW-1:0] dmem_addr;
    logic dmem_re, dmem_we;
    logic [WIDTH-1:0] dmem_rdata, dmem_wdata;
    logic [IWIDTH-1:0] alu_op;
    logic [1:0] alu_src1, alu_src2;
    logic [WIDTH-1:0] alu_rf_a, alu_word, alu_imm, alu_out, cr;
    logic alu_bit, alu_c_in, alu_c_out, alu_flag_valid;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .PC_W(PC_W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_rf_a(alu_rf_a),
        .alu_word(alu_word), .alu_bit(alu_bit), .alu_imm(alu_imm), .alu_c_in(alu_c_in),
        .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_flag_valid(alu_flag_valid), .cr(cr)
    );

    // Program ROM with an ack that arrives ack_delay cycles into a request.
    logic [IW-1:0] rom [0:255];
    int ack_delay;
    int wait_cnt;
    assign imem_data = rom[imem_addr];
    assign imem_ack  = imem_req && (wait_cnt >= ack_delay);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
    end

    // Data memory: synchronous read, write on we; poke port preloads it.
    logic [WIDTH-1:0] dmem [0:255];
    logic poke_en;
    logic [7:0] poke_addr, poke_data;
    always_ff @(posedge clk) begin
        if (poke_en)      dmem[poke_addr] <= poke_data;
        else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        if (dmem_re)      dmem_rdata <= dmem[dmem_addr];
    end

    // Behavioural ALU.
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   sum;
    always_comb begin
        case (alu_src1)
            2'd0:    a = alu_rf_a;
            2'd1:    a = {{(WIDTH-1){1'b0}}, alu_bit};
            2'd2:    a = alu_word;
            default: a = alu_imm;
        endcase
        case (alu_src2)
            2'd0:    b = alu_rf_a;
            2'd1:    b = {{(WIDTH-1){1'b0}}, alu_bit};
            2'd2:    b = alu_word;
            default: b = alu_imm;
        endcase
        sum            = '0;
        alu_out        = a;
        alu_c_out      = 1'b0;
        alu_flag_valid = 1'b0;
        case (alu_op)
            OP_AND: alu_out = a & b;
            OP_OR:  alu_out = a | b;
            OP_XOR: alu_out = a ^ b;
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                alu_out = sum[WIDTH-1:0]; alu_c_out = sum[WIDTH]; alu_flag_valid = 1'b1;
            end
            OP_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                alu_out = sum[WIDTH-1:0]; alu_c_out = sum[WIDTH]; alu_flag_valid = 1'b1;
            end
            OP_NOT, OP_LDN, OP_STN: alu_out = ~a;
            OP_S:   alu_out = '1;
            OP_R:   alu_out = '0;
            default: alu_out = a;
        endcase
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       c;
    } wr_t;

    logic [PC_W-1:0] fq [$];
    wr_t wq [$];
    int checks = 0;
    int errors = 0;

    function automatic logic [IW-1:0] ins(input logic [7:0] op, input logic [1:0] s, input logic [7:0] opd);
        return {op, s, opd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare fetches and writes against the predicted queues.
    task automatic sb_check();
        logic [PC_W-1:0] fexp;
        wr_t wexp;
        if (!rst && imem_req && imem_ack) begin
            checks++;
            assert (fq.size() != 0) else begin
                errors++;
                $error("FAIL fetch_unexpected observed=%0h expected=none", imem_addr);
            end
            if (fq.size() != 0) begin
                fexp = fq.pop_front();
                check("fetch_addr", 32'(imem_addr), 32'(fexp));
            end
        end
        if (!rst && dmem_we) begin
            check("we_re_excl", 32'(dmem_re), 32'h0);
            checks++;
            assert (wq.size() != 0) else begin
                errors++;
                $error("FAIL write_unexpected observed=%0h:%0h expected=none", dmem_addr, dmem_wdata);
            end
            if (wq.size() != 0) begin
                wexp = wq.pop_front();
                check("wr_addr", 32'(dmem_addr), 32'(wexp.addr));
                check("wr_data", 32'(dmem_wdata), 32'(wexp.data));
                check("wr_carry", 32'(alu_c_in), 32'(wexp.c));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
    endtask

    task automatic poke(input logic [7:0] ad, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = ad; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(halted), 32'h1);
    endtask

    task automatic push_fetch(input logic [PC_W-1:0] ad);
        fq.push_back(ad);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack_delay = 0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        for (int i = 0; i < 256; i++) rom[i] = ins(OP_END, 2'd0, 8'h00);

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_dmem_strobes", 32'({dmem_re, dmem_we}), 32'h0);
        check("rst_cr", 32'(cr), 32'h0);
        check("rst_carry", 32'(alu_c_in), 32'h0);
        check("rst_pc", 32'(imem_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        poke(8'h10, 8'h7F);
        poke(8'h40, 8'h01);

        // LD imm 5; ADD imm 3; END
        rom[0] = ins(OP_LD, SRC_IMM, 8'h05);
        rom[1] = ins(OP_ADD, SRC_IMM, 8'h03);
        rom[2] = ins(OP_END, SRC_RF, 8'h00);
        for (int i = 0; i < 3; i++) push_fetch(PC_W'(i));
        pulse_start();
        wait_halt(7, "t1_halt_latency");
        check("t1_cr", 32'(cr), 32'h08);
        check("t1_carry", 32'(alu_c_in), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_pc_at_end", 32'(imem_addr), 32'h02);

        // Word load, add with carry-free overflow to 0x80, store, NOP store, carry out
        rom[0] = ins(OP_LD, SRC_WORD, 8'h10);
        rom[1] = ins(OP_ADD, SRC_IMM, 8'h01);
        rom[2] = ins(OP_ST, SRC_WORD, 8'h11);
        rom[3] = ins(OP_ST, SRC_IMM, 8'h11);
        rom[4] = ins(OP_LD, SRC_IMM, 8'hFF);
        rom[5] = ins(OP_ADD, SRC_IMM, 8'h01);
        rom[6] = ins(OP_END, SRC_RF, 8'h00);
        for (int i = 0; i < 7; i++) push_fetch(PC_W'(i));
        wq.push_back('{addr: 8'h11, data: 8'h80, c: 1'b0});
        pulse_start();
        wait_halt(40, "t2_halt");
        check("t2_cr", 32'(cr), 32'h00);
        check("t2_carry", 32'(alu_c_in), 32'h1);
        check("t2_dmem11", 32'(dmem[8'h11]), 32'h80);

        // Conditional set: no write with CR=0, write 0xFF with CR=1
        rom[0] = ins(OP_LD, SRC_IMM, 8'h00);
        rom[1] = ins(OP_S, SRC_WORD, 8'h20);
        rom[2] = ins(OP_LD, SRC_IMM, 8'h01);
        rom[3] = ins(OP_S, SRC_WORD, 8'h20);
        rom[4] = ins(OP_END, SRC_RF, 8'h00);
        for (int i = 0; i < 5; i++) push_fetch(PC_W'(i));
        wq.push_back('{addr: 8'h20, data: 8'hFF, c: 1'b1});
        pulse_start();
        wait_halt(40, "t3_halt");
        check("t3_dmem20", 32'(dmem[8'h20]), 32'hFF);
        check("t3_cr", 32'(cr), 32'h01);

        // PC wrap: CR=1 on entry, JMPC to 0xFD, run through 0xFF and wrap to 0
        rom[0]    = ins(OP_JMPC, SRC_RF, 8'hFD);
        rom[1]    = ins(OP_END, SRC_RF, 8'h00);
        rom[8'hFD] = ins(OP_LD, SRC_IMM, 8'h00);
        rom[8'hFE] = ins(OP_JMP, SRC_RF, 8'hFF);
        rom[8'hFF] = ins(OP_LD, SRC_IMM, 8'h00);
        push_fetch(8'h00); push_fetch(8'hFD); push_fetch(8'hFE);
        push_fetch(8'hFF); push_fetch(8'h00); push_fetch(8'h01);
        pulse_start();
        wait_halt(40, "t4_halt");
        check("t4_pc_at_end", 32'(imem_addr), 32'h01);
        check("t4_cr", 32'(cr), 32'h00);

        // JMPC taken with CR=1 (flag cleared by R), not taken with CR=0
        rom[0] = ins(OP_LD, SRC_WORD, 8'h40);
        rom[1] = ins(OP_R, SRC_WORD, 8'h40);
        rom[2] = ins(OP_JMPC, SRC_RF, 8'h00);
        rom[3] = ins(OP_END, SRC_RF, 8'h00);
        push_fetch(8'h00); push_fetch(8'h01); push_fetch(8'h02);
        push_fetch(8'h00); push_fetch(8'h01); push_fetch(8'h02); push_fetch(8'h03);
        wq.push_back('{addr: 8'h40, data: 8'h00, c: 1'b1});
        pulse_start();
        wait_halt(60, "t5_halt");
        check("t5_cr", 32'(cr), 32'h00);
        check("t5_dmem40", 32'(dmem[8'h40]), 32'h00);

        // Slow fetch: request and address held, no memory or ALU activity
        ack_delay = 5;
        rom[0] = ins(OP_LD, SRC_IMM, 8'h42);
        rom[1] = ins(OP_END, SRC_RF, 8'h00);
        push_fetch(8'h00); push_fetch(8'h01);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("t6_req_held", 32'(imem_req), 32'h1);
            check("t6_addr_stable", 32'(imem_addr), 32'h00);
            check("t6_no_dmem", 32'({dmem_re, dmem_we}), 32'h0);
            check("t6_alu_op_held", 32'(alu_op), 32'(OP_R));
            tick();
        end
        wait_halt(60, "t6_halt");
        check("t6_cr", 32'(cr), 32'h42);
        ack_delay = 0;

        // Reset while in OPRD
        rom[0] = ins(OP_LD, SRC_WORD, 8'h10);
        rom[1] = ins(OP_END, SRC_RF, 8'h00);
        push_fetch(8'h00);
        pulse_start();
        for (int n = 0; n < 10 && dmem_re !== 1'b1; n++) tick();
        check("t7_oprd_reached", 32'(dmem_re), 32'h1);
        rst = 1'b1;
        #1;
        check("t7_rst_re", 32'(dmem_re), 32'h0);
        check("t7_rst_busy", 32'(busy), 32'h0);
        check("t7_rst_cr", 32'(cr), 32'h00);
        check("t7_rst_req", 32'(imem_req), 32'h0);
        tick();
        rst = 1'b0;
        push_fetch(8'h00); push_fetch(8'h01);
        pulse_start();
        wait_halt(40, "t7_halt");
        check("t7_cr", 32'(cr), 32'h7F);

        // Reset while a fetch is pending
        ack_delay = 50;
        pulse_start();
        tick(); tick(); tick();
        check("t8_pending_req", 32'(imem_req), 32'h1);
        rst = 1'b1;
        #1;
        check("t8_rst_req", 32'(imem_req), 32'h0);
        check("t8_rst_busy", 32'(busy), 32'h0);
        check("t8_rst_cr", 32'(cr), 32'h00);
        tick();
        rst = 1'b0;
        ack_delay = 0;
        push_fetch(8'h00); push_fetch(8'h01);
        pulse_start();
        wait_halt(40, "t8_halt");
        check("t8_cr", 32'(cr), 32'h7F);

        check("fetch_q_drained", 32'(fq.size()), 32'h0);
        check("write_q_drained", 32'(wq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
